// File: rtl/dds_meter_pkg.sv
// Shared constants and FSM state type for the DDS waveform meter.
package dds_meter_pkg;

    localparam int DW_DEF   = 12;
    localparam int CW_DEF   = 16;
    localparam int MID_DEF  = 2048;
    localparam int HYST_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEEK = 2'd1,
        ST_MEAS = 2'd2
    } meter_state_t;

endpackage

// File: rtl/dds_xdet.sv
// Schmitt rising-crossing detector: arms below the band, fires once above it.
module dds_xdet #(
    parameter int DW   = 12,
    parameter int MID  = 2048,
    parameter int HYST = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_din_vld,
    input  logic [DW-1:0] i_din,
    output logic          o_xr
);

    localparam logic [DW-1:0] LO_TH = DW'(MID - HYST);
    localparam logic [DW-1:0] HI_TH = DW'(MID + HYST);

    logic r_armed;
    logic w_lo;
    logic w_hi;

    assign w_lo = (i_din < LO_TH);
    assign w_hi = (i_din >= HI_TH);
    assign o_xr = i_en & i_din_vld & r_armed & w_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else if (!i_en) begin
            r_armed <= 1'b0;
        end else if (i_din_vld) begin
            if (o_xr)
                r_armed <= 1'b0;
            else if (w_lo)
                r_armed <= 1'b1;
        end
    end

endmodule

// File: rtl/dds_wave_meter.sv
// Measures period, peak, trough and peak-to-peak of a DDS sample stream,
// one result per rising crossing once the first full period has been seen.
module dds_wave_meter
    import dds_meter_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int MID  = MID_DEF,
    parameter int HYST = HYST_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          din_vld,
    input  logic [DW-1:0] din,
    output logic          meas_vld,
    output logic [CW-1:0] period,
    output logic [DW-1:0] max_val,
    output logic [DW-1:0] min_val,
    output logic [DW-1:0] vpp,
    output logic          locked,
    output logic          timeout
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    meter_state_t  r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_max;
    logic [DW-1:0] r_min;
    logic          r_meas_vld;
    logic [CW-1:0] r_period;
    logic [DW-1:0] r_max_val;
    logic [DW-1:0] r_min_val;
    logic [DW-1:0] r_vpp;
    logic          r_locked;
    logic          r_timeout;
    logic          w_xr;

    dds_xdet #(
        .DW   (DW),
        .MID  (MID),
        .HYST (HYST)
    ) u_xdet (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (en),
        .i_din_vld (din_vld),
        .i_din     (din),
        .o_xr      (w_xr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_max      <= '0;
            r_min      <= '0;
            r_meas_vld <= 1'b0;
            r_period   <= '0;
            r_max_val  <= '0;
            r_min_val  <= '0;
            r_vpp      <= '0;
            r_locked   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_meas_vld <= 1'b0;
            r_timeout  <= 1'b0;
            if (!en) begin
                r_state  <= ST_IDLE;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_SEEK;
                    ST_SEEK: begin
                        if (w_xr) begin
                            r_state <= ST_MEAS;
                            r_cnt   <= CNT_ONE;
                            r_max   <= din;
                            r_min   <= din;
                        end
                    end
                    ST_MEAS: begin
                        // A crossing on the saturating sample still counts as a measurement.
                        if (w_xr) begin
                            r_period   <= r_cnt;
                            r_max_val  <= r_max;
                            r_min_val  <= r_min;
                            r_vpp      <= r_max - r_min;
                            r_meas_vld <= 1'b1;
                            r_locked   <= 1'b1;
                            r_cnt      <= CNT_ONE;
                            r_max      <= din;
                            r_min      <= din;
                        end else if (din_vld) begin
                            if (r_cnt == CNT_MAX) begin
                                r_timeout <= 1'b1;
                                r_locked  <= 1'b0;
                                r_state   <= ST_SEEK;
                            end else begin
                                r_cnt <= r_cnt + CNT_ONE;
                                if (din > r_max) r_max <= din;
                                if (din < r_min) r_min <= din;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign meas_vld = r_meas_vld;
    assign period   = r_period;
    assign max_val  = r_max_val;
    assign min_val  = r_min_val;
    assign vpp      = r_vpp;
    assign locked   = r_locked;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_dds_wave_meter.sv
// Randomized bench for dds_wave_meter against a sample-queue reference model.
module tb_dds_wave_meter;

    localparam int LO_TH   = 2048 - 64;
    localparam int HI_TH   = 2048 + 64;
    localparam int MAX_PER = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        din_vld;
    logic [11:0] din;
    logic        meas_vld;
    logic [15:0] period;
    logic [11:0] max_val;
    logic [11:0] min_val;
    logic [11:0] vpp;
    logic        locked;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    // reference model: samples of the period currently being collected
    int q[$];
    bit m_active, m_tracking, m_armed, m_locked, m_meas, m_to;
    int m_period, m_max, m_min, m_vpp;

    dds_wave_meter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .din_vld  (din_vld),
        .din      (din),
        .meas_vld (meas_vld),
        .period   (period),
        .max_val  (max_val),
        .min_val  (min_val),
        .vpp      (vpp),
        .locked   (locked),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 0; m_tracking = 0; m_armed = 0; m_locked = 0;
        m_meas = 0; m_to = 0;
        m_period = 0; m_max = 0; m_min = 0; m_vpp = 0;
    endtask

    task automatic model_step(input bit e, input bit v, input int d);
        bit xr;
        int mx, mn;
        m_meas = 0;
        m_to   = 0;
        if (!e) begin
            m_active = 0; m_tracking = 0; m_armed = 0; m_locked = 0;
            q.delete();
            return;
        end
        xr = 0;
        if (v) begin
            xr = m_armed && (d >= HI_TH);
            if (xr) m_armed = 0;
            else if (d < LO_TH) m_armed = 1;
        end
        if (!m_active) begin
            m_active = 1;
            return;
        end
        if (!v) return;
        if (m_tracking) begin
            if (xr) begin
                mx = 0; mn = 4095;
                foreach (q[i]) begin
                    if (q[i] > mx) mx = q[i];
                    if (q[i] < mn) mn = q[i];
                end
                m_period = q.size();
                m_max = mx; m_min = mn; m_vpp = mx - mn;
                m_meas = 1; m_locked = 1;
                q.delete();
                q.push_back(d);
            end else if (q.size() == MAX_PER) begin
                m_to = 1; m_locked = 0; m_tracking = 0;
                q.delete();
            end else begin
                q.push_back(d);
            end
        end else if (xr) begin
            m_tracking = 1;
            q.delete();
            q.push_back(d);
        end
    endtask

    task automatic step(input bit e, input bit v, input int d);
        en = e; din_vld = v; din = 12'(d);
        @(posedge clk);
        model_step(e, v, d);
        #1;
        chk("meas_vld", meas_vld, m_meas);
        chk("timeout",  timeout,  m_to);
        chk("locked",   locked,   m_locked);
        chk("period",   period,   m_period);
        chk("max_val",  max_val,  m_max);
        chk("min_val",  min_val,  m_min);
        chk("vpp",      vpp,      m_vpp);
    endtask

    task automatic square(input int n, input bit gaps);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < 200; i++) begin
                if (gaps) step(1, 0, $urandom_range(0, 4095));
                step(1, 1, (i < 100) ? 0 : 4095);
            end
    endtask

    function automatic int tri_wave(input int ph);
        return (ph < 2048) ? 2 * ph : 2 * (4095 - ph);
    endfunction

    initial begin
        int ph, lo_len, hi_len, lo_lvl, hi_lvl, to_at;
        rst_n = 1'b0; en = 1'b0; din_vld = 1'b0; din = '0;
        model_reset();
        #3;
        chk("rst_meas_vld", meas_vld, 0);
        chk("rst_locked",   locked,   0);
        chk("rst_period",   period,   0);
        #10 rst_n = 1'b1;
        step(0, 1, 0);

        // square lock, then asynchronous reset while measuring
        square(4, 0);
        chk("sq_period", period, 200);
        chk("sq_max",    max_val, 4095);
        chk("sq_min",    min_val, 0);
        chk("sq_vpp",    vpp, 4095);
        chk("sq_locked", locked, 1);
        for (int i = 0; i < 37; i++) step(1, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_period",   period, 0);
        chk("arst_max",      max_val, 0);
        chk("arst_vpp",      vpp, 0);
        chk("arst_locked",   locked, 0);
        chk("arst_meas_vld", meas_vld, 0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        square(3, 0);

        // valid gaps: period counts samples, not clocks
        square(4, 1);
        chk("gap_period", period, 200);

        // triangle, Fword=4 Pword=512
        ph = 512;
        for (int i = 0; i < 3 * 1024; i++) begin
            step(1, 1, tri_wave(ph));
            ph = (ph + 4) % 4096;
        end
        chk("tri_period", period, 1024);

        // random square-ish bursts with in-band noise, gaps and rare en drops
        for (int b = 0; b < 14; b++) begin
            lo_len = $urandom_range(5, 200); hi_len = $urandom_range(5, 200);
            lo_lvl = $urandom_range(0, LO_TH - 1); hi_lvl = $urandom_range(HI_TH, 4095);
            if ($urandom_range(0, 9) == 0) step(0, 1, 0);
            for (int i = 0; i < lo_len + hi_len; i++) begin
                if ($urandom_range(0, 7) == 0)
                    step(1, 1, $urandom_range(LO_TH, HI_TH - 1));
                else
                    step(1, $urandom_range(0, 3) != 0,
                         (i < lo_len) ? $urandom_range(0, lo_lvl) : $urandom_range(hi_lvl, 4095));
            end
        end

        // en dropped during measurement, then re-enabled
        square(3, 0);
        step(0, 1, 0);
        chk("en_drop_locked", locked, 0);
        chk("en_drop_period", period, 200);
        step(0, 1, 4095);
        square(3, 0);

        // lock then hold high: timeout 65535 samples after the last crossing
        square(2, 0);
        for (int i = 0; i < 100; i++) step(1, 1, 0);
        to_at = -1;
        for (int i = 1; i <= 65600; i++) begin
            step(1, 1, 4095);
            if (timeout && to_at < 0) to_at = i;
        end
        chk("timeout_pos",    to_at, 65536);
        chk("timeout_locked", locked, 0);
        chk("timeout_period", period, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
